// File: rtl/bpsk_modulator.sv
// BPSK modulator: bit FIFO, symbol FSM, free-running carrier phase and a registered +/-cos output.
// Optional preamble generator compiled in with `define BPSK_MOD_PREAMBLE_EN.

`ifndef SAMPLES_PER_SYMBOL
`define SAMPLES_PER_SYMBOL 80
`endif
`ifndef FIXDT_32_WIDTH
`define FIXDT_32_WIDTH 32
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 64
`endif
`ifndef SAMPLING_FREQ
`define SAMPLING_FREQ 100000000
`endif
`ifndef CARRIER_FREQ
`define CARRIER_FREQ 1562500
`endif

// 64-entry cosine table built from a 17-point quarter wave, amplitude 32767.
module cosine_lut #(
  parameter int W = 32
) (
  input  logic [5:0]          angle_i,
  output logic signed [W-1:0] cos_o
);

  function automatic logic [15:0] quarter(input logic [4:0] k);
    case (k)
      5'd0:    quarter = 16'd32767;
      5'd1:    quarter = 16'd32609;
      5'd2:    quarter = 16'd32137;
      5'd3:    quarter = 16'd31356;
      5'd4:    quarter = 16'd30273;
      5'd5:    quarter = 16'd28898;
      5'd6:    quarter = 16'd27245;
      5'd7:    quarter = 16'd25329;
      5'd8:    quarter = 16'd23170;
      5'd9:    quarter = 16'd20787;
      5'd10:   quarter = 16'd18204;
      5'd11:   quarter = 16'd15446;
      5'd12:   quarter = 16'd12539;
      5'd13:   quarter = 16'd9512;
      5'd14:   quarter = 16'd6393;
      5'd15:   quarter = 16'd3212;
      5'd16:   quarter = 16'd0;
      default: quarter = 16'd0;
    endcase
  endfunction

  logic [4:0]          j_s;
  logic [4:0]          k_s;
  logic signed [W-1:0] mag_s;
  logic                neg_s;

  // Odd quadrants read the table mirrored; quadrants 1 and 2 are negative.
  always_comb begin
    j_s   = {1'b0, angle_i[3:0]};
    k_s   = angle_i[4] ? (5'd16 - j_s) : j_s;
    neg_s = angle_i[5] ^ angle_i[4];
    mag_s = $signed({{(W-16){1'b0}}, quarter(k_s)});
    if (neg_s) begin
      cos_o = -mag_s;
    end else begin
      cos_o = mag_s;
    end
  end

endmodule

module bpsk_modulator #(
  parameter int SAMPLES_PER_SYMBOL   = `SAMPLES_PER_SYMBOL,
  parameter int FIFO_DEPTH           = 4,
  parameter int INITIAL_PHASE_OFFSET = 0,
  parameter int PREAMBLE_SYMBOLS     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bit_in,
  input  logic                              bit_valid,
  output logic                              bit_ready,
  output logic signed [`FIXDT_32_WIDTH-1:0] sample_out,
  output logic                              sample_valid,
  output logic                              symbol_start,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int W    = `FIXDT_32_WIDTH;
  localparam int AW   = $clog2(`CARRIER_SAMPLES_PER_PERIOD);
  localparam int STEP = `CARRIER_SAMPLES_PER_PERIOD / (`SAMPLING_FREQ / `CARRIER_FREQ);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam int CW   = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLES_PER_SYMBOL - 1);

`ifdef BPSK_MOD_PREAMBLE_EN
  localparam int PCW = (PREAMBLE_SYMBOLS > 1) ? $clog2(PREAMBLE_SYMBOLS) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2} state_t;
  logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, DATA = 1'b1} state_t;
  logic preamble_unused;
  assign preamble_unused = (PREAMBLE_SYMBOLS > 0);
`endif

  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
    if (v == {1'b1, {(W-1){1'b0}}}) begin
      neg_sat = {1'b0, {(W-1){1'b1}}};
    end else begin
      neg_sat = -v;
    end
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       sym_cnt_q, sym_cnt_d;
  logic                cur_bit_q, cur_bit_d;
  logic [AW-1:0]       lu_angle_q;
  logic                mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic                push_s, pop_s, head_s, active_s;
  logic signed [W-1:0] lut_s;
  logic signed [W-1:0] sample_q;
  logic                valid_q, start_q;

  assign bit_ready    = (level_q != LW'(FIFO_DEPTH));
  assign push_s       = bit_valid && bit_ready;
  assign head_s       = mem_q[rd_ptr_q];
  assign active_s     = (state_q != IDLE);
  assign busy         = active_s;
  assign fifo_level   = level_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign symbol_start = start_q;

  cosine_lut #(.W(W)) u_lut (
    .angle_i (lu_angle_q),
    .cos_o   (lut_s)
  );

  // Carrier phase runs in every state so the phase stays continuous across idle gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_angle_q <= AW'(INITIAL_PHASE_OFFSET);
    end else begin
      lu_angle_q <= lu_angle_q + AW'(STEP);
    end
  end

  // Bit FIFO; pointer wrap relies on FIFO_DEPTH being a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= bit_in;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Symbol FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      cur_bit_q <= 1'b0;
`ifdef BPSK_MOD_PREAMBLE_EN
      pre_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      cur_bit_q <= cur_bit_d;
`ifdef BPSK_MOD_PREAMBLE_EN
      pre_cnt_q <= pre_cnt_d;
`endif
    end
  end

  // Symbol FSM next state: a bit is popped only when a new data symbol is loaded.
  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    cur_bit_d = cur_bit_q;
    pop_s     = 1'b0;
`ifdef BPSK_MOD_PREAMBLE_EN
    pre_cnt_d = pre_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        sym_cnt_d = '0;
        if (level_q != '0) begin
`ifdef BPSK_MOD_PREAMBLE_EN
          state_d   = PREAMBLE;
          cur_bit_d = 1'b1;
          pre_cnt_d = '0;
`else
          state_d   = DATA;
          cur_bit_d = head_s;
          pop_s     = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef BPSK_MOD_PREAMBLE_EN
      PREAMBLE: begin
        if (sym_cnt_q == LAST_CNT) begin
          sym_cnt_d = '0;
          if (pre_cnt_q == PCW'(PREAMBLE_SYMBOLS - 1)) begin
            if (level_q != '0) begin
              state_d   = DATA;
              cur_bit_d = head_s;
              pop_s     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            pre_cnt_d = pre_cnt_q + PCW'(1);
            cur_bit_d = ~cur_bit_q;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + CW'(1);
        end
      end
`endif
      DATA: begin
        if (sym_cnt_q == LAST_CNT) begin
          sym_cnt_d = '0;
          if (level_q != '0) begin
            cur_bit_d = head_s;
            pop_s     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        sym_cnt_d = '0;
      end
    endcase
  end

  // Output register: signed carrier while a symbol is active, zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      valid_q  <= active_s;
      start_q  <= active_s && (sym_cnt_q == '0);
      sample_q <= active_s ? (cur_bit_q ? lut_s : neg_sat(lut_s)) : '0;
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Scoreboard bench for bpsk_modulator: accepted bits are queued, a negedge monitor checks every sample.
`ifndef SAMPLES_PER_SYMBOL
`define SAMPLES_PER_SYMBOL 80
`endif
`ifndef FIXDT_32_WIDTH
`define FIXDT_32_WIDTH 32
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 64
`endif
`ifndef SAMPLING_FREQ
`define SAMPLING_FREQ 100000000
`endif
`ifndef CARRIER_FREQ
`define CARRIER_FREQ 1562500
`endif

module tb_bpsk_modulator;

  localparam int  SPS   = `SAMPLES_PER_SYMBOL;
  localparam int  W     = `FIXDT_32_WIDTH;
  localparam int  NPER  = `CARRIER_SAMPLES_PER_PERIOD;
  localparam int  STEP  = NPER / (`SAMPLING_FREQ / `CARRIER_FREQ);
  localparam int  OFF   = 0;
  localparam int  TOL   = 2;
`ifdef BPSK_MOD_PREAMBLE_EN
  localparam int  PRE   = 8;
`else
  localparam int  PRE   = 0;
`endif
  localparam real PI    = 3.14159265358979;

  logic                clk;
  logic                rst;
  logic                bit_in;
  logic                bit_valid;
  logic                bit_ready;
  logic signed [W-1:0] sample_out;
  logic                sample_valid;
  logic                symbol_start;
  logic                busy;
  logic [2:0]          fifo_level;

  bpsk_modulator #(
    .SAMPLES_PER_SYMBOL   (SPS),
    .FIFO_DEPTH           (4),
    .INITIAL_PHASE_OFFSET (OFF),
    .PREAMBLE_SYMBOLS     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .symbol_start (symbol_start),
    .busy         (busy),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];
  int ph_cyc = 0;

  // Edges since reset release; the sample registered at edge n used carrier phase OFF+(n-1)*STEP.
  always @(posedge clk) begin
    if (rst) ph_cyc <= 0;
    else     ph_cyc <= ph_cyc + 1;
  end

  function automatic int ref_cos(input int cyc);
    int  a;
    real r;
    a = (OFF + (cyc - 1) * STEP) % NPER;
    r = 32767.0 * $cos(2.0 * PI * real'(a) / real'(NPER));
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Monitor state
  bit prev_valid = 1'b0;
  bit cur_exp    = 1'b0;
  bit pre_bit    = 1'b1;
  int mon_cnt    = 0;
  int burst_len  = 0;
  int last_burst = 0;
  int nsym       = 0;
  int pre_left   = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      mon_cnt    = 0;
      burst_len  = 0;
      pre_left   = 0;
    end else begin
      if (sample_valid) begin
        if (!prev_valid) begin
          burst_len = 0;
          pre_left  = PRE;
          pre_bit   = 1'b1;
          check("burst_first_is_start", symbol_start, 1);
        end
        if (symbol_start) begin
          if (prev_valid) check("symbol_length", mon_cnt, SPS);
          nsym++;
          mon_cnt = 0;
          if (pre_left > 0) begin
            cur_exp  = pre_bit;
            pre_bit  = !pre_bit;
            pre_left--;
          end else if (exp_q.size() == 0) begin
            fail("unexpected_symbol", "symbol started with no accepted bit pending");
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end else if (mon_cnt >= SPS) begin
          fail("symbol_too_long", $sformatf("sample %0d of symbol without symbol_start", mon_cnt));
        end
        begin
          int c, e, d;
          c = ref_cos(ph_cyc);
          e = cur_exp ? c : -c;
          d = int'(sample_out) - e;
          n_cmp++;
          if (d > TOL || d < -TOL) begin
            n_err++;
            $display("FAIL sample: got %0d expected %0d (bit %0d, idx %0d, t=%0t)",
                     sample_out, e, cur_exp, mon_cnt, $time);
          end
        end
        mon_cnt++;
        burst_len++;
      end else begin
        if (prev_valid) begin
          check("last_symbol_length", mon_cnt, SPS);
          last_burst = burst_len;
        end
        check("idle_sample_zero", sample_out, 0);
        check("idle_no_start", symbol_start, 0);
      end
      prev_valid = sample_valid;
    end
  end

  // Offer one bit at a negedge until accepted; returns on the negedge after the accepting edge.
  task automatic push_bit(input bit b);
    bit acc;
    bit done;
    done      = 1'b0;
    bit_valid = 1'b1;
    bit_in    = b;
    for (int t = 0; t < 4 * SPS * (PRE + 2) && !done; t++) begin
      acc = bit_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(b);
        done = 1'b1;
      end
      @(negedge clk);
    end
    bit_valid = 1'b0;
    if (!done) fail("push_timeout", "bit_ready never asserted");
  endtask

  task automatic latency_probe();
    check("lat_e0_valid", sample_valid, 0);
    check("lat_e0_level", fifo_level, 1);
    @(negedge clk);
    check("lat_e1_valid", sample_valid, 0);
    check("lat_e1_busy", busy, 1);
    check("lat_e1_level", fifo_level, (PRE > 0) ? 1 : 0);
    @(negedge clk);
    check("lat_e2_valid", sample_valid, 1);
    check("lat_e2_start", symbol_start, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 6000 && !done; t++) begin
      @(negedge clk);
      if (!busy && !sample_valid && fifo_level == 3'd0) done = 1'b1;
    end
    @(negedge clk);
    if (!done) fail("idle_timeout", "modulator never returned to idle");
    check("queue_drained", exp_q.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int n0, first_drop, b4[4];
    rst       = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;

    // Reset hold
    repeat (10) @(negedge clk);
    check("rst_sample_out", sample_out, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_symbol_start", symbol_start, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_bit_ready", bit_ready, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_bit_ready", bit_ready, 1);

    // Single bit 1 with latency probe
    n0 = nsym;
    push_bit(1'b1);
    latency_probe();
    wait_idle();
    check("single_burst_len", last_burst, SPS * (PRE + 1));
    check("single_nsym", nsym - n0, PRE + 1);

    // Back-to-back 1,0,1,0
    n0   = nsym;
    b4   = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) push_bit(b4[i][0]);
    wait_idle();
    check("b2b_burst_len", last_burst, SPS * (PRE + 4));
    check("b2b_nsym", nsym - n0, PRE + 4);

    // FIFO fill with bit_valid held
    first_drop = -1;
    for (int i = 0; i < 6; i++) begin
      push_bit(1'($urandom_range(0, 1)));
      if (!bit_ready && first_drop < 0) first_drop = i + 1;
    end
    check("ready_drop_after", first_drop, (PRE > 0) ? 4 : 5);
    wait_idle();

    // Mid-symbol reset with bits queued
    for (int i = 0; i < 4; i++) push_bit(1'($urandom_range(0, 1)));
    begin
      bit hit;
      hit = 1'b0;
      for (int t = 0; t < 4 * SPS && !hit; t++) begin
        @(negedge clk);
        if (sample_valid && mon_cnt >= 40) hit = 1'b1;
      end
      if (!hit) fail("mid_symbol_timeout", "never reached sample 40");
    end
    check("pre_rst_level", fifo_level, (PRE > 0) ? 4 : 3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sample_out", sample_out, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_start", symbol_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", bit_ready, 1);
    exp_q.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push_bit(1'($urandom_range(0, 1)));
    latency_probe();
    wait_idle();

    // Random bits with random gaps
    for (int i = 0; i < 24; i++) begin
      push_bit(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2 * SPS)) @(negedge clk);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
